// File: rtl/mult_control_unit.sv
// mult_control_unit
// Moore sequencing FSM for a shift-and-add mantissa multiplier.
// The state register is one-hot. Every strobe is registered and decoded
// from the next state, so the outputs are glitch-free and always match the
// state that is being entered.
// Optional macro CYCLE_LIMIT_EN adds a shift counter. With the counter, a
// multiply ends after WIDTH shifts even if the zero flag never asserts.
// Reset is asynchronous and active-low.

module mult_control_unit #(
    parameter int WIDTH = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic lsb,
    input  logic zero,
    output logic init,
    output logic load,
    output logic clear,
    output logic shift,
    output logic out_en
);

    typedef enum logic [5:0] {
        IDLE  = 6'b000001,
        INIT  = 6'b000010,
        TEST  = 6'b000100,
        ADD   = 6'b001000,
        SHIFT = 6'b010000,
        DONE  = 6'b100000
    } state_t;

    state_t state;
    state_t state_next;
    logic   limit_hit;

    // A zero-width mantissa makes no sense for the counter or the datapath.
    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("mult_control_unit: WIDTH must be at least 1");
        end
    endgenerate

`ifdef CYCLE_LIMIT_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] count;

    // Shift counter: cleared when operands load, bumped once per SHIFT cycle.
    // The counter never passes WIDTH, because TEST leaves for DONE at WIDTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (state == INIT) begin
            count <= '0;
        end else if (state == SHIFT) begin
            count <= count + 1'b1;
        end
    end

    assign limit_hit = (count == CNT_W'(WIDTH));
`else
    assign limit_hit = 1'b0;
`endif

    // Next-state decode. Inputs are looked at only in IDLE, TEST and DONE.
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = start ? INIT : IDLE;
            INIT:    state_next = TEST;
            TEST: begin
                if (zero || limit_hit) begin
                    state_next = DONE;
                end else if (lsb) begin
                    state_next = ADD;
                end else begin
                    state_next = SHIFT;
                end
            end
            ADD:     state_next = SHIFT;
            SHIFT:   state_next = TEST;
            DONE:    state_next = start ? DONE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register and registered output strobes. The strobes are decoded
    // from the state being entered, so they line up with that state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            init   <= 1'b0;
            clear  <= 1'b0;
            load   <= 1'b0;
            shift  <= 1'b0;
            out_en <= 1'b0;
        end else begin
            state  <= state_next;
            init   <= (state_next == INIT);
            clear  <= (state_next == INIT);
            load   <= (state_next == ADD);
            shift  <= (state_next == SHIFT);
            out_en <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_mult_control_unit.sv
// tb_mult_control_unit
// Table-driven check of the multiplier sequencer. The bench adds
// hand-written sequences for reset, asynchronous abort and (when
// CYCLE_LIMIT_EN is defined) the WIDTH-bounded termination.
// Output vector order: {init, clear, load, shift, out_en}.

module tb_mult_control_unit;

    logic clk;
    logic reset;
    logic start;
    logic lsb;
    logic zero;
    logic init;
    logic load;
    logic clear;
    logic shift;
    logic out_en;

    int n_cmp;
    int n_bad;

    localparam logic [4:0] O_IDLE  = 5'b00000;
    localparam logic [4:0] O_INIT  = 5'b11000;
    localparam logic [4:0] O_ADD   = 5'b00100;
    localparam logic [4:0] O_SHIFT = 5'b00010;
    localparam logic [4:0] O_DONE  = 5'b00001;

    typedef struct {
        logic       start;
        logic       lsb;
        logic       zero;
        logic [4:0] exp;
        string      name;
    } vec_t;

    localparam int NVEC = 27;
    vec_t vecs [NVEC];

    mult_control_unit #(
        .WIDTH(4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .lsb    (lsb),
        .zero   (zero),
        .init   (init),
        .load   (load),
        .clear  (clear),
        .shift  (shift),
        .out_en (out_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {init, clear, load, shift, out_en};
    endfunction

    task automatic check(input string name, input logic [4:0] exp);
        n_cmp++;
        if (outs() !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, required %b", name, outs(), exp);
        end else begin
            $display("ok   %s: outputs %b", name, outs());
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic s, input logic l, input logic z,
                                input logic [4:0] e, input string n);
        vec_t v;
        v.start = s;
        v.lsb   = l;
        v.zero  = z;
        v.exp   = e;
        v.name  = n;
        return v;
    endfunction

    initial begin
        int n_shift;
        bit done_seen;

        n_cmp = 0;
        n_bad = 0;

        // Each entry gives the inputs applied before an edge and the outputs
        // expected after that edge.
        vecs[0]  = mk(1, 0, 1, O_INIT,  "zero_init");
        vecs[1]  = mk(1, 0, 1, O_IDLE,  "zero_test");
        vecs[2]  = mk(1, 0, 1, O_DONE,  "zero_done");
        vecs[3]  = mk(1, 0, 0, O_DONE,  "zero_hold");
        vecs[4]  = mk(0, 0, 0, O_IDLE,  "zero_release");
        vecs[5]  = mk(0, 1, 1, O_IDLE,  "idle_stay");
        vecs[6]  = mk(1, 1, 0, O_INIT,  "walk_init");
        vecs[7]  = mk(1, 1, 0, O_IDLE,  "walk_test0");
        vecs[8]  = mk(1, 1, 0, O_ADD,   "walk_add0");
        vecs[9]  = mk(1, 0, 1, O_SHIFT, "walk_shift0");
        vecs[10] = mk(1, 0, 0, O_IDLE,  "walk_test1");
        vecs[11] = mk(1, 0, 0, O_SHIFT, "walk_shift1");
        vecs[12] = mk(1, 1, 0, O_IDLE,  "walk_test2");
        vecs[13] = mk(1, 1, 0, O_ADD,   "walk_add2");
        vecs[14] = mk(1, 1, 0, O_SHIFT, "walk_shift2");
        vecs[15] = mk(1, 0, 0, O_IDLE,  "walk_test3");
        vecs[16] = mk(1, 0, 1, O_DONE,  "walk_done");
        vecs[17] = mk(0, 0, 0, O_IDLE,  "walk_release");
        vecs[18] = mk(1, 1, 1, O_INIT,  "prio_init");
        vecs[19] = mk(1, 1, 1, O_IDLE,  "prio_test");
        vecs[20] = mk(1, 1, 1, O_DONE,  "prio_done");
        vecs[21] = mk(1, 0, 0, O_DONE,  "no_restart");
        vecs[22] = mk(0, 0, 0, O_IDLE,  "prio_release");
        vecs[23] = mk(1, 0, 0, O_INIT,  "restart_init");
        vecs[24] = mk(1, 0, 1, O_IDLE,  "restart_test");
        vecs[25] = mk(1, 0, 1, O_DONE,  "restart_done");
        vecs[26] = mk(0, 0, 0, O_IDLE,  "restart_release");

        // Reset held with every input active: outputs must stay low.
        reset = 1'b0;
        start = 1'b1;
        lsb   = 1'b1;
        zero  = 1'b1;
        #1;
        check("reset_async", O_IDLE);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("reset_hold%0d", i), O_IDLE);
        end
        start = 1'b0;
        lsb   = 1'b0;
        zero  = 1'b0;
        reset = 1'b1;
        step();
        check("reset_released_idle", O_IDLE);

        // Directed vector table.
        for (int i = 0; i < NVEC; i++) begin
            start = vecs[i].start;
            lsb   = vecs[i].lsb;
            zero  = vecs[i].zero;
            step();
            check(vecs[i].name, vecs[i].exp);
        end

`ifdef CYCLE_LIMIT_EN
        // With zero never asserted, the counter must stop the multiply
        // after exactly WIDTH (4) shifts.
        start = 1'b1;
        lsb   = 1'b0;
        zero  = 1'b0;
        step();
        check("limit_init", O_INIT);
        n_shift   = 0;
        done_seen = 1'b0;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            step();
            if (shift) n_shift++;
            if (out_en) done_seen = 1'b1;
        end
        n_cmp++;
        if (n_shift != 4) begin
            n_bad++;
            $display("FAIL limit_shifts: got %0d shift pulses, required 4", n_shift);
        end else begin
            $display("ok   limit_shifts: %0d shift pulses", n_shift);
        end
        n_cmp++;
        if (!done_seen) begin
            n_bad++;
            $display("FAIL limit_done: out_en never rose within 40 cycles, required 1");
        end else begin
            $display("ok   limit_done: out_en reached");
        end
        start = 1'b0;
        step();
        check("limit_release", O_IDLE);
`else
        n_shift   = 0;
        done_seen = 1'b0;
`endif

        // Reset in the middle of a multiply aborts immediately. After release,
        // the first edge sees IDLE with start high.
        start = 1'b1;
        lsb   = 1'b0;
        zero  = 1'b0;
        step();
        check("midop_init", O_INIT);
        step();
        check("midop_test", O_IDLE);
        step();
        check("midop_shift", O_SHIFT);
        #1;
        reset = 1'b0;
        #1;
        check("midop_abort", O_IDLE);
        #9;
        check("midop_abort_held", O_IDLE);
        reset = 1'b1;
        step();
        check("midop_reinit", O_INIT);
        start = 1'b0;
        step();
        check("midop_after_test", O_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_control_unit.md
Name: mult_control_unit

Overview:
- Moore-type sequencing FSM for a shift-and-add mantissa multiplier inside the floating-point multiply datapath.
- Drives the datapath's operand-load, accumulator-clear, add and shift strobes.
- Inspects the multiplier LSB and a multiplier-is-zero flag.
- Raises out_en when the product register holds the final result.

Parameters:
- WIDTH, 24, mantissa width in bits. Sizes the iteration counter; used only when CYCLE_LIMIT_EN is defined.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  level request to begin a multiply
- lsb  input  1  current LSB of the multiplier register
- zero  input  1  multiplier register is all zeros
- init  output  1  load multiplicand/multiplier operand registers
- load  output  1  add multiplicand into product accumulator
- clear  output  1  clear product accumulator
- shift  output  1  shift multiplier right and multiplicand left
- out_en  output  1  product valid / output register enable

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset).
- While reset=0: state=IDLE and all outputs 0, immediately (no clock needed).
- State register is one-hot, updated on posedge clk. Outputs are decoded only from the state, never from inputs, so they are glitch-free and change one cycle after the deciding edge.
- States and outputs:
  - IDLE: all outputs 0. start=1 -> INIT; else stay.
  - INIT: init=1, clear=1 for exactly one cycle; always -> TEST.
  - TEST: all outputs 0.
    - zero=1 -> DONE (zero has priority over lsb).
    - else lsb=1 -> ADD.
    - else -> SHIFT.
  - ADD: load=1 for one cycle; always -> SHIFT.
  - SHIFT: shift=1 for one cycle; always -> TEST.
  - DONE: out_en=1. Stays while start=1; start=0 -> IDLE.
- Per multiplier bit: 2 cycles if the bit is 0 (TEST, SHIFT), 3 cycles if 1 (TEST, ADD, SHIFT).
- Latency from start sampled high to out_en: 3 cycles minimum, when zero=1 on the first TEST.
- start is level-sensitive and sampled only in IDLE and DONE. Holding start high after DONE does not restart; start must drop to 0 and rise again.
- lsb and zero are ignored outside TEST.
- At most one of init/load/shift/out_en is high in any cycle; clear is high only together with init.
- Reset asserted mid-operation aborts immediately to IDLE with outputs 0. On release, the first edge evaluates IDLE (start=1 -> INIT).
- Unreachable/illegal state encodings recover to IDLE on the next edge.

Optional Feature:
- Macro CYCLE_LIMIT_EN.
- Defined: adds a ceil(log2(WIDTH+1))-bit shift counter.
  - Counter clears in INIT and increments in SHIFT.
  - TEST goes to DONE when zero=1 OR count==WIDTH, bounding a multiply to WIDTH shifts even if zero never asserts.
- Undefined: no counter; termination is by zero only.

Test Plan:
- Reset: reset=0 with start=1, lsb=1, zero=1 -> all outputs 0 and state IDLE; outputs stay 0 across several edges.
- Immediate zero: reset=1, start=1, zero=1 -> init=clear=1 for one cycle, then a TEST cycle with all outputs 0, then out_en=1 held while start=1; start=0 -> out_en=0 next cycle.
- Bit walk: zero=0, lsb sequence 1,0,1 then zero=1 -> pulses load, shift, shift, load, shift, then out_en=1; init=1 exactly once.
- Mid-op reset: after INIT, drop reset to 0 for 10 ns -> all outputs 0 immediately. Re-raise reset with start=1 -> new init/clear pulse on the next edge.
- Priority: lsb=1 and zero=1 in TEST -> DONE, load never asserted.
- CYCLE_LIMIT_EN with WIDTH=4, zero=0, lsb=0 -> exactly 4 shift pulses, then out_en=1.
